// File: rtl/vsync_pkg.sv
// Shared constants and symbol classification for the Gigatron VSYNC decoder.
package vsync_pkg;

  // Default Gigatron encoding: HSYNC pulses per VSYNC window for each bit value.
  localparam int GIGA_ZERO_HS = 7;
  localparam int GIGA_ONE_HS  = 9;
  localparam int GIGA_DATA_W  = 8;

  // err_count saturates here.
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Meaning of one completed VSYNC window.
  typedef enum logic [1:0] {
    SYM_ZERO,
    SYM_ONE,
    SYM_BAD
  } sym_e;

  // Map an HSYNC count onto a symbol; anything not exactly matching is bad.
  function automatic sym_e classify(input int count, input int zero_hs, input int one_hs);
    if (count == zero_hs) begin
      return SYM_ZERO;
    end
    if (count == one_hs) begin
      return SYM_ONE;
    end
    return SYM_BAD;
  endfunction

endpackage

// File: rtl/vsync_decoder_if.sv
// Output word stream of the VSYNC decoder.
//
// Handshake: the master holds tx_data and tx_valid stable until it sees
// tx_ready; a word is transferred on every rising clock edge where both
// tx_valid and tx_ready are high. tx_ready may be held high freely and is
// allowed to depend on tx_valid; tx_valid never depends on tx_ready.
interface vsync_decoder_if #(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/vsync_fifo.sv
// Small synchronous FIFO holding assembled words until the consumer takes them.
// The head word is presented combinationally from the storage array so a push
// into an empty FIFO is visible on the very next cycle.
module vsync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign valid = !empty;

  // When full, a same-cycle pop frees the slot the new word lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  // Head is forced to zero while empty so nothing stale leaks out.
  assign head = empty ? '0 : mem[rd_ptr];

  // Storage array: written only, never reset; validity comes from count.
  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vsync_decoder.sv
// Recovers data bits that the Gigatron encodes as the number of HSYNC pulses
// inside each VSYNC-low window, assembles them into words and queues the words
// for a valid/ready consumer.
module vsync_decoder
  import vsync_pkg::*;
#(
  parameter int DATA_W     = GIGA_DATA_W,
  parameter int ZERO_HS    = GIGA_ZERO_HS,
  parameter int ONE_HS     = GIGA_ONE_HS,
  parameter int HS_CNT_W   = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                CLOCK_50,
  input  logic                reset_n,
  input  logic                gigatron_vga_hs,
  input  logic                gigatron_vga_vs,
  vsync_decoder_if.master     tx,
  output logic                frame_err,
  output logic [7:0]          err_count,
  output logic                overflow,
  input  logic                ovf_clr,
  output logic [HS_CNT_W-1:0] dbg_hscount
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0]     BC_LAST = BC_W'(DATA_W - 1);
  localparam logic [HS_CNT_W-1:0] HS_MAX  = '1;

  // Synchronizers (two flops) plus one delay flop per sync input.
  logic hs_s1, hs_s2, hs_d;
  logic vs_s1, vs_s2, vs_d;

  logic hs_fall;
  logic vs_fall;
  logic vs_rise;

  logic [HS_CNT_W-1:0] hs_cnt;
  sym_e                sym;

  logic [BC_W-1:0]     bit_cnt;
  logic [BC_W-1:0]     bit_idx;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_ins;

  logic                valid_bit;
  logic                bad_window;
  logic                word_done;

  logic [DATA_W-1:0]   fifo_head;
  logic                fifo_valid;
  logic                fifo_full;
  logic                fifo_drop;
  logic                fifo_pop;

  // Bring the asynchronous sync lines into the clock domain; idle level is high.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      hs_s1 <= 1'b1;
      hs_s2 <= 1'b1;
      hs_d  <= 1'b1;
      vs_s1 <= 1'b1;
      vs_s2 <= 1'b1;
      vs_d  <= 1'b1;
    end else begin
      hs_s1 <= gigatron_vga_hs;
      hs_s2 <= hs_s1;
      hs_d  <= hs_s2;
      vs_s1 <= gigatron_vga_vs;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
    end
  end

  assign hs_fall = hs_d & ~hs_s2;
  assign vs_fall = vs_d & ~vs_s2;
  assign vs_rise = ~vs_d & vs_s2;

  // HSYNC pulse counter: cleared at window start, counts only inside the window.
  // A VS fall wins over a coincident HS fall, so that HS edge is not counted.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      hs_cnt <= '0;
    end else if (vs_fall) begin
      hs_cnt <= '0;
    end else if (!vs_s2 && hs_fall && (hs_cnt != HS_MAX)) begin
      hs_cnt <= hs_cnt + 1'b1;
    end
  end

  // Classify the closing window and build the word with the new bit inserted.
  always_comb begin
    sym        = classify(int'(hs_cnt), ZERO_HS, ONE_HS);
    valid_bit  = vs_rise && (sym != SYM_BAD);
    bad_window = vs_rise && (sym == SYM_BAD);
    word_done  = valid_bit && (bit_cnt == BC_LAST);
    bit_idx    = (MSB_FIRST != 0) ? (BC_LAST - bit_cnt) : bit_cnt;
    shreg_ins  = shreg;
    for (int i = 0; i < DATA_W; i++) begin
      if (BC_W'(i) == bit_idx) begin
        shreg_ins[i] = (sym == SYM_ONE);
      end
    end
  end

  // Word assembly: a bad window throws away the partial word; a full word is
  // handed to the FIFO in the same cycle and assembly restarts from zero.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      dbg_hscount <= '0;
    end else begin
      if (vs_rise) begin
        dbg_hscount <= hs_cnt;
      end
      if (bad_window || word_done) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (valid_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= shreg_ins;
      end
    end
  end

  // One-cycle error strobe for each bad window.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= bad_window;
    end
  end

  // Error statistics; a clear request beats any same-cycle update.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n || ovf_clr) begin
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (bad_window && (err_count != ERR_CNT_MAX)) begin
        err_count <= err_count + 1'b1;
      end
      if (fifo_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign fifo_pop = fifo_valid && tx.tx_ready;

  vsync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .push      (word_done),
    .push_data (shreg_ins),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .drop      (fifo_drop)
  );

  assign tx.tx_data  = fifo_head;
  assign tx.tx_valid = fifo_valid;

endmodule

// File: tb/tb_vsync_decoder.sv
// Bench for vsync_decoder: drives HSYNC/VSYNC pin waveforms, predicts words
// from the HSYNC counts it sends and checks them through an expected queue.
module tb_vsync_decoder;
  import vsync_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  logic hs       = 1'b1;
  logic vs       = 1'b1;
  logic ovf_clr  = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  vsync_decoder_if #(.DATA_W(8)) tx_if ();
  vsync_decoder_if #(.DATA_W(4)) tx2_if ();

  logic       frame_err, overflow;
  logic [7:0] err_count;
  logic [4:0] dbg;
  logic       frame_err2, overflow2;
  logic [7:0] err_count2;
  logic [4:0] dbg2;

  vsync_decoder #(
    .DATA_W(8), .ZERO_HS(7), .ONE_HS(9), .HS_CNT_W(5), .FIFO_DEPTH(4), .MSB_FIRST(0)
  ) u_dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .gigatron_vga_hs(hs), .gigatron_vga_vs(vs),
    .tx(tx_if.master),
    .frame_err(frame_err), .err_count(err_count), .overflow(overflow),
    .ovf_clr(ovf_clr), .dbg_hscount(dbg)
  );

  vsync_decoder #(
    .DATA_W(4), .ZERO_HS(7), .ONE_HS(9), .HS_CNT_W(5), .FIFO_DEPTH(4), .MSB_FIRST(1)
  ) u_dut2 (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n),
    .gigatron_vga_hs(hs), .gigatron_vga_vs(vs),
    .tx(tx2_if.master),
    .frame_err(frame_err2), .err_count(err_count2), .overflow(overflow2),
    .ovf_clr(ovf_clr), .dbg_hscount(dbg2)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp2_q[$];
  bit         chk2 = 1'b0;
  int         acc_cnt = 0;
  int         fe_cnt = 0;
  bit         fe_prev = 1'b0;
  bit         fe_long = 1'b0;

  typedef struct {
    int         c[8];
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      hs = 1'b0; tick(2);
      hs = 1'b1; tick(2);
    end
  endtask

  task automatic send_window(input int n);
    vs = 1'b0; tick(3);
    pulses(n);
    tick(2);
    vs = 1'b1; tick(8);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_window(w[i] ? 9 : 7);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      tick(1);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain timeout pending %0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitors ----------------
  // Samples on the falling edge: what is seen here is what the DUT acts on next.
  always @(negedge CLOCK_50) begin
    if (reset_n && tx_if.tx_valid && tx_if.tx_ready) begin
      checks++;
      acc_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %0h expected none", tx_if.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_if.tx_data !== e) begin
          errors++;
          $display("FAIL word got %0h expected %0h", tx_if.tx_data, e);
        end
      end
    end
    if (reset_n && frame_err) begin
      fe_cnt++;
      if (fe_prev) fe_long = 1'b1;
    end
    fe_prev = reset_n && frame_err;
  end

  always @(negedge CLOCK_50) begin
    if (reset_n && chk2 && tx2_if.tx_valid) begin
      checks++;
      if (exp2_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word_msb got %0h expected none", tx2_if.tx_data);
      end else begin
        logic [3:0] e2;
        e2 = exp2_q.pop_front();
        if (tx2_if.tx_data !== e2) begin
          errors++;
          $display("FAIL word_msb got %0h expected %0h", tx2_if.tx_data, e2);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int         fe0;
    int         a0;
    int         k;
    logic [7:0] w;
    logic [7:0] ovf_words[5];

    vecs[0].c = '{9, 7, 9, 7, 7, 7, 7, 7}; vecs[0].exp = 8'h05;
    vecs[1].c = '{7, 7, 7, 7, 7, 7, 7, 7}; vecs[1].exp = 8'h00;
    vecs[2].c = '{9, 9, 9, 9, 9, 9, 9, 9}; vecs[2].exp = 8'hFF;
    vecs[3].c = '{7, 9, 7, 9, 7, 9, 7, 9}; vecs[3].exp = 8'hAA;
    vecs[4].c = '{9, 9, 9, 9, 7, 7, 7, 7}; vecs[4].exp = 8'h0F;
    vecs[5].c = '{7, 7, 7, 7, 7, 7, 7, 9}; vecs[5].exp = 8'h80;

    tx_if.tx_ready  = 1'b1;
    tx2_if.tx_ready = 1'b1;
    reset_n = 1'b0;
    tick(3);
    check("rst_tx_valid", tx_if.tx_valid, 0);
    check("rst_tx_data", tx_if.tx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dbg_hscount", dbg, 0);
    reset_n = 1'b1;
    tick(2);

    // MSB-first, 4-bit instance: counts 9,7,7,7 give 4'h8.
    chk2 = 1'b1;
    exp2_q.push_back(4'h8);
    send_window(9); send_window(7); send_window(7); send_window(7);
    k = 0;
    while (exp2_q.size() != 0 && k < 50) begin tick(1); k++; end
    check("msb_word_pending", exp2_q.size(), 0);
    tick(2);
    chk2 = 1'b0;
    exp2_q.delete();

    // Fresh start for the main instance (it holds 4 partial bits now).
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(2);

    // Table vectors.
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt;
      a0  = acc_cnt;
      exp_q.push_back(vecs[v].exp);
      for (int i = 0; i < 8; i++) send_window(vecs[v].c[i]);
      wait_drain("vec_drain");
      check("vec_accepts", acc_cnt - a0, 1);
      check("vec_frame_err", fe_cnt - fe0, 0);
      check("vec_dbg_hscount", dbg, vecs[v].c[7]);
    end

    // Random words.
    for (int r = 0; r < 4; r++) begin
      w = 8'($urandom_range(0, 255));
      exp_q.push_back(w);
      send_word(w);
      wait_drain("rand_drain");
    end

    // Three valid bits then a count of 8: partial word discarded.
    fe0 = fe_cnt;
    send_window(9); send_window(9); send_window(9);
    send_window(8);
    check("err8_frame_err_pulses", fe_cnt - fe0, 1);
    check("err8_err_count", err_count, 1);
    check("err8_dbg_hscount", dbg, 8);
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    wait_drain("err8_drain");

    // 40 pulses saturate the 5-bit counter at 31.
    fe0 = fe_cnt;
    send_window(40);
    check("sat_dbg_hscount", dbg, 31);
    check("sat_frame_err_pulses", fe_cnt - fe0, 1);
    check("sat_err_count", err_count, 2);

    // Overflow: consumer stalled, five words into a four-deep FIFO.
    ovf_words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    tx_if.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(ovf_words[i]);
    for (int i = 0; i < 5; i++) send_word(ovf_words[i]);
    check("ovf_overflow_set", overflow, 1);
    check("ovf_head_valid", tx_if.tx_valid, 1);
    check("ovf_head_data", tx_if.tx_data, 8'h11);
    tick(5);
    check("ovf_head_stable", tx_if.tx_data, 8'h11);
    tx_if.tx_ready = 1'b1;
    wait_drain("ovf_drain");
    tick(4);
    check("ovf_fifo_empty", tx_if.tx_valid, 0);
    check("ovf_overflow_sticky", overflow, 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    check("ovf_clr_overflow", overflow, 0);
    check("ovf_clr_err_count", err_count, 0);

    // Reset in the middle of a window, with partial word bits pending.
    send_window(9); send_window(7); send_window(9);
    vs = 1'b0; tick(3);
    pulses(4);
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    check("midrst_tx_valid", tx_if.tx_valid, 0);
    check("midrst_err_count", err_count, 0);
    check("midrst_dbg_hscount", dbg, 0);
    tick(2);
    vs = 1'b1; tick(8);
    a0 = acc_cnt;
    exp_q.push_back(8'hA5);
    send_word(8'hA5);
    wait_drain("midrst_drain");
    tick(4);
    check("midrst_accepts", acc_cnt - a0, 1);

    check("frame_err_single_cycle", fe_long, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
